// File: rtl/negate_arbiter.sv
// negate_arbiter: round-robin shared conditional-negate datapath with registered tagged result and overflow counters
module negate_arbiter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [7:0]       req0_a,
  input  logic             req0_sign,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_a,
  input  logic             req1_sign,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_d,
  output logic             res_ovfl,
  output logic             res_id,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ovfl_cnt0,
  output logic [CNT_W-1:0] ovfl_cnt1
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic             r_last;
  logic             r_res_valid;
  logic [7:0]       r_res_d;
  logic             r_res_ovfl;
  logic             r_res_id;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;
  logic             w_can_acc;
  logic             w_grant;
  logic             w_issue;
  logic [7:0]       w_a;
  logic             w_sign;
  logic [7:0]       w_d;
  logic             w_ovfl;
  // Grant defaults to requester 0 when idle so its ready is visible before valid.
  always_comb begin
    w_can_acc = ~r_res_valid | res_ready;
    w_grant   = (req0_valid & req1_valid) ? ~r_last : req1_valid;
    w_issue   = w_can_acc & (w_grant ? req1_valid : req0_valid);
    w_a       = w_grant ? req1_a : req0_a;
    w_sign    = w_grant ? req1_sign : req0_sign;
    w_d       = w_sign ? (~w_a + 8'd1) : w_a;
    w_ovfl    = w_sign & (w_a == 8'h80);
  end
  assign req0_ready = w_can_acc & ~w_grant;
  assign req1_ready = w_can_acc & w_grant;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last      <= 1'b1;
      r_res_valid <= 1'b0;
      r_res_d     <= 8'h00;
      r_res_ovfl  <= 1'b0;
      r_res_id    <= 1'b0;
    end else if (w_issue) begin
      r_last      <= w_grant;
      r_res_valid <= 1'b1;
      r_res_d     <= w_d;
      r_res_ovfl  <= w_ovfl;
      r_res_id    <= w_grant;
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_issue && w_ovfl) begin
      if (!w_grant && r_cnt0 != CNT_MAX) r_cnt0 <= r_cnt0 + 1'b1;
      if (w_grant && r_cnt1 != CNT_MAX) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end
  assign res_valid = r_res_valid;
  assign res_d     = r_res_d;
  assign res_ovfl  = r_res_ovfl;
  assign res_id    = r_res_id;
  assign ovfl_cnt0 = r_cnt0;
  assign ovfl_cnt1 = r_cnt1;
endmodule

// File: tb/tb_negate_arbiter.sv
// tb_negate_arbiter: directed vectors with hand-computed expectations for negate_arbiter
module tb_negate_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_sign, req0_ready;
  logic [7:0] req0_a;
  logic       req1_valid, req1_sign, req1_ready;
  logic [7:0] req1_a;
  logic       res_valid, res_ready, res_ovfl, res_id;
  logic [7:0] res_d;
  logic       cnt_clr;
  logic [3:0] ovfl_cnt0, ovfl_cnt1;
  int n_tests = 0;
  int n_fail = 0;

  negate_arbiter #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_sign(req0_sign), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_sign(req1_sign), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_d(res_d), .res_ovfl(res_ovfl), .res_id(res_id),
    .cnt_clr(cnt_clr), .ovfl_cnt0(ovfl_cnt0), .ovfl_cnt1(ovfl_cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string tag, input logic [7:0] d, input logic ovfl, input logic id);
    chk({tag, "_valid"}, res_valid, 1);
    chk({tag, "_d"}, res_d, d);
    chk({tag, "_ovfl"}, res_ovfl, ovfl);
    chk({tag, "_id"}, res_id, id);
  endtask

  task automatic drive0(input logic v, input logic [7:0] a, input logic s);
    req0_valid = v; req0_a = a; req0_sign = s;
  endtask

  task automatic drive1(input logic v, input logic [7:0] a, input logic s);
    req1_valid = v; req1_a = a; req1_sign = s;
  endtask

  initial begin
    rst = 1'b1; res_ready = 1'b1; cnt_clr = 1'b0;
    drive0(0, 8'h00, 0); drive1(0, 8'h00, 0);
    tick(); tick();
    chk("rst_valid", res_valid, 0);
    chk("rst_d", res_d, 0);
    chk("rst_ovfl", res_ovfl, 0);
    chk("rst_id", res_id, 0);
    chk("rst_cnt0", ovfl_cnt0, 0);
    chk("rst_cnt1", ovfl_cnt1, 0);
    rst = 1'b0;
    // single negate
    drive0(1, 8'h05, 1); #1;
    chk("first_rdy0", req0_ready, 1);
    chk("first_rdy1", req1_ready, 0);
    tick(); drive0(0, 8'h00, 0);
    chk_res("neg05", 8'hFB, 0, 0);
    tick();
    chk("drain_valid", res_valid, 0);
    // contention alternates starting from requester 0 after reset
    rst = 1'b1; tick(); rst = 1'b0;
    drive0(1, 8'h01, 0); drive1(1, 8'h02, 1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("alt_rdy0_%0d", i), req0_ready, (i % 2 == 0));
      chk($sformatf("alt_rdy1_%0d", i), req1_ready, (i % 2 == 1));
      tick();
      chk_res($sformatf("alt_%0d", i), (i % 2 == 0) ? 8'h01 : 8'hFE, 0, (i % 2 == 1));
    end
    drive0(0, 8'h00, 0);
    // overflow and saturation on requester 1
    drive1(1, 8'h80, 1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk_res($sformatf("ovf_%0d", k), 8'h80, 1, 1);
      chk($sformatf("cnt1_%0d", k), ovfl_cnt1, (k < 15) ? k : 15);
    end
    chk("cnt0_after_ovf", ovfl_cnt0, 0);
    drive1(0, 8'h00, 0);
    // boundary operands
    drive0(1, 8'h80, 0); tick();
    chk_res("pass80", 8'h80, 0, 0);
    chk("pass80_cnt0", ovfl_cnt0, 0);
    drive0(1, 8'h00, 1); tick();
    chk_res("neg00", 8'h00, 0, 0);
    drive0(1, 8'h7F, 1); tick();
    chk_res("neg7f", 8'h81, 0, 0);
    // backpressure
    drive0(1, 8'h10, 1); tick();
    chk_res("bp_load", 8'hF0, 0, 0);
    res_ready = 1'b0;
    drive0(1, 8'h20, 0); drive1(1, 8'h30, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_rdy0_%0d", i), req0_ready, 0);
      chk($sformatf("bp_rdy1_%0d", i), req1_ready, 0);
      tick();
      chk_res($sformatf("bp_hold_%0d", i), 8'hF0, 0, 0);
    end
    drive1(0, 8'h00, 0); res_ready = 1'b1; #1;
    chk("bp_release_rdy0", req0_ready, 1);
    tick();
    chk_res("bp_overwrite", 8'h20, 0, 0);
    // counter clear wins over same-cycle increment
    drive0(1, 8'h80, 1); tick();
    chk("cnt0_inc", ovfl_cnt0, 1);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk_res("clr_issue", 8'h80, 1, 0);
    chk("clr_cnt0", ovfl_cnt0, 0);
    chk("clr_cnt1", ovfl_cnt1, 0);
    // reset while holding a result; leave last=0 first
    drive0(0, 8'h00, 0); drive1(1, 8'h80, 1); tick();
    chk("pre_rst_cnt1", ovfl_cnt1, 1);
    drive1(0, 8'h00, 0); drive0(1, 8'h01, 0); tick();
    chk_res("pre_rst_res", 8'h01, 0, 0);
    drive0(0, 8'h00, 0); res_ready = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_cnt0", ovfl_cnt0, 0);
    chk("mid_rst_cnt1", ovfl_cnt1, 0);
    drive0(1, 8'h03, 0); drive1(1, 8'h04, 0); #1;
    chk("post_rst_rdy0", req0_ready, 1);
    chk("post_rst_rdy1", req1_ready, 0);
    tick();
    chk_res("post_rst_res", 8'h03, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/negate_arbiter.md
Name: negate_arbiter

Overview:
- Shares one 8-bit two's-complement sign-change datapath (conditional negate plus overflow detect) between two requesters.
- Arbitration is round-robin with valid/ready handshakes on both requester ports and on the result port.
- The result is registered with an owner tag.
- Per-requester saturating overflow counters are kept for status readback.
- Sits between the operand sources and the downstream consumer of signed results.

Parameters:
- CNT_W, 4, width of each saturating overflow counter (max value 2^CNT_W-1).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- req0_valid  input  1  requester 0 has an operand
- req0_a  input  8  requester 0 operand, two's complement
- req0_sign  input  1  1 = negate operand, 0 = pass through
- req0_ready  output  1  requester 0 operand accepted this cycle
- req1_valid  input  1  requester 1 has an operand
- req1_a  input  8  requester 1 operand
- req1_sign  input  1  requester 1 negate select
- req1_ready  output  1  requester 1 operand accepted this cycle
- res_valid  output  1  result register holds a valid result
- res_ready  input  1  consumer takes result this cycle
- res_d  output  8  result value
- res_ovfl  output  1  overflow flag for this result
- res_id  output  1  owner of result (0 or 1)
- cnt_clr  input  1  synchronous clear of both overflow counters
- ovfl_cnt0  output  CNT_W  saturating count of requester-0 overflows
- ovfl_cnt1  output  CNT_W  saturating count of requester-1 overflows

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values:
  - res_valid=0, res_d=0, res_ovfl=0, res_id=0.
  - ovfl_cnt0=0, ovfl_cnt1=0.
  - Round-robin pointer last=1, so requester 0 wins first.
  - rst mid-operation drops any held result with no output handshake, and clears the counters.
- Datapath (combinational, on the granted operand):
  - d = sign ? (~a + 1) mod 256 : a.
  - ovfl = sign & (a == 8'h80). The result for 0x80 negated is 0x80 with ovfl=1.
  - Negating 0x00 gives 0x00 with ovfl=0.
  - sign=0 never sets ovfl.
- Accept condition: can_acc = ~res_valid | res_ready.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester != last.
  - reqX_ready = can_acc & grant==X. The ready outputs are combinational and never both 1.
  - Ready may depend on valid. Requesters must not make valid depend on ready.
- Issue on reqX_valid & reqX_ready:
  - The next edge loads res_d, res_ovfl and res_id=X, and sets res_valid=1.
  - last is updated to X.
  - Latency is 1 cycle from accept to res_valid.
- last changes only on an accepted issue. A cycle with no issue keeps last.
- Drain on res_valid & res_ready with no issue the same cycle: res_valid goes to 0.
- Simultaneous drain and issue: the register is overwritten with the new result and res_valid stays 1. Sustained throughput is 1 op/cycle.
- Backpressure: while res_valid & ~res_ready, all of res_d, res_ovfl and res_id hold stable and both ready outputs are 0.
- Counters:
  - On an issue with ovfl=1, the owner's counter increments, saturating at 2^CNT_W-1 (no wrap).
  - cnt_clr has priority over a same-cycle increment: the counter becomes 0.
- Inputs with valid=0 are ignored regardless of a/sign values.

Test Plan:
- Reset, then req0_valid=1, a=0x05, sign=1, res_ready=1 -> req0_ready=1 in cycle 0; next cycle res_valid=1, res_d=0xFB, res_ovfl=0, res_id=0.
- Both requesters valid continuously, res_ready=1 (req0 a=0x01 sign=0, req1 a=0x02 sign=1):
  - grants alternate 0,1,0,1 starting with 0;
  - results alternate 0x01 (id 0) and 0xFE (id 1), one per cycle.
- req1 a=0x80 sign=1 -> res_d=0x80, res_ovfl=1, ovfl_cnt1=1. Repeat 20 times with CNT_W=4 -> ovfl_cnt1 saturates at 15.
- Boundary operands:
  - req0 a=0x80 sign=0 -> res_d=0x80, res_ovfl=0, no count.
  - a=0x00 sign=1 -> 0x00, ovfl=0.
  - a=0x7F sign=1 -> 0x81.
- Backpressure:
  - res_ready=0 for 3 cycles with a result held -> res_* stable, both ready outputs 0.
  - Then res_ready=1 with req0 valid -> drain and new issue in the same cycle, res_valid stays 1.
- Clear and reset:
  - cnt_clr=1 in the same cycle as an overflowing issue -> counter reads 0.
  - rst while res_valid=1 -> next cycle res_valid=0, counters 0, next contention granted to requester 0.
